// File: rtl/poly_reduce_if.sv
// Handshake and RAM-port bundle between the reduction FSM and its environment.
// The FSM connects through the slave modport; the product RAM and controller use master.
interface poly_reduce_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 13
);
  logic             start;
  logic             prod_rd_en;
  logic [10:0]      prod_addr;
  logic [IN_W-1:0]  prod_data;
  logic             out_we;
  logic [9:0]       out_addr;
  logic [OUT_W-1:0] out_data;
  logic             busy;
  logic             done;

  modport master (
    output start, prod_data,
    input  prod_rd_en, prod_addr, out_we, out_addr, out_data, busy, done
  );

  modport slave (
    input  start, prod_data,
    output prod_rd_en, prod_addr, out_we, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/poly_reduce_fsm.sv
// Reduces a raw product modulo x^P - x - 1 and then each coefficient modulo Q.
// Define POLY_REDUCE_CENTER_EN to emit centred two's-complement coefficients.
module poly_reduce_fsm #(
  parameter int P         = 757,
  parameter int Q         = 5167,
  parameter int IN_W      = 26,
  parameter int OUT_W     = 13,
  parameter int MOD_STEPS = 16
) (
  input  logic         clk,
  input  logic         rst,
  poly_reduce_if.slave bus
);
  localparam int SUM_W = IN_W + 2;
  localparam int S_W   = $clog2(MOD_STEPS);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RDLO = 3'd1;
  localparam logic [2:0] RDHI = 3'd2;
  localparam logic [2:0] SUM  = 3'd3;
  localparam logic [2:0] MOD  = 3'd4;
  localparam logic [2:0] WR   = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  logic [2:0]       state_reg;
  logic [9:0]       j_reg;
  logic [IN_W-1:0]  lo_reg;
  logic [IN_W-1:0]  prev_reg;
  logic [SUM_W-1:0] r_reg;
  logic [S_W-1:0]   s_reg;

  logic             last;
  logic [IN_W-1:0]  hi;
  logic [63:0]      q_tab [MOD_STEPS];
  logic [63:0]      q_shift;
  logic [OUT_W-1:0] r_low;
  logic [OUT_W-1:0] wr_value;

  // Subtrahend table Q<<gi for the restoring-division steps.
  for (genvar gi = 0; gi < MOD_STEPS; gi++) begin : g_qtab
    assign q_tab[gi] = 64'(Q) << gi;
  end

  assign last    = (j_reg == 10'(P - 1));
  assign hi      = last ? '0 : bus.prod_data;
  assign q_shift = q_tab[s_reg];
  assign r_low   = r_reg[OUT_W-1:0];

`ifdef POLY_REDUCE_CENTER_EN
  assign wr_value = (r_reg > SUM_W'((Q - 1) / 2)) ? (r_low - OUT_W'(Q)) : r_low;
`else
  assign wr_value = r_low;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      j_reg     <= '0;
      lo_reg    <= '0;
      prev_reg  <= '0;
      r_reg     <= '0;
      s_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            j_reg     <= '0;
            prev_reg  <= '0;
            state_reg <= RDLO;
          end
        end
        RDLO: state_reg <= RDHI;
        RDHI: begin
          lo_reg    <= bus.prod_data;
          state_reg <= SUM;
        end
        SUM: begin
          // prev carries c_{j+P} into the next coefficient as its c_{j+P-1} term.
          r_reg     <= SUM_W'(lo_reg) + SUM_W'(hi) + SUM_W'(prev_reg);
          prev_reg  <= hi;
          s_reg     <= S_W'(MOD_STEPS - 1);
          state_reg <= MOD;
        end
        MOD: begin
          if (64'(r_reg) >= q_shift) r_reg <= r_reg - q_shift[SUM_W-1:0];
          if (s_reg == '0) state_reg <= WR;
          else             s_reg     <= s_reg - 1'b1;
        end
        WR: begin
          if (last) begin
            state_reg <= DONE;
          end else begin
            j_reg     <= j_reg + 1'b1;
            state_reg <= RDLO;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.prod_rd_en = 1'b0;
    bus.prod_addr  = '0;
    bus.out_we     = 1'b0;
    bus.out_addr   = '0;
    bus.out_data   = '0;
    if (state_reg == RDLO) begin
      bus.prod_rd_en = 1'b1;
      bus.prod_addr  = 11'(j_reg);
    end
    if (state_reg == RDHI && !last) begin
      bus.prod_rd_en = 1'b1;
      bus.prod_addr  = 11'(j_reg) + 11'(P);
    end
    if (state_reg == WR) begin
      bus.out_we   = 1'b1;
      bus.out_addr = j_reg;
      bus.out_data = wr_value;
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = (state_reg == DONE);
endmodule
